multi_stage_controller: RTL
===========================

# multi_stage_controller

Instruction sequencer that sits directly upstream of the multi-stage ALU and the register file. It accepts one 10-bit instruction per valid/ready handshake and steps a fixed-latency state machine. Each step drives the ALU controls (Ain, Gin, Gout, FN) and the register-file and bus enables (Rin, Rout, EXTout), one bus driver per cycle. It signals completion with a one-cycle DONE pulse.

## Interface
- N, 10, instruction and bus width; instruction fields below are fixed for N=10
- NREG, 4, number of general registers (Rx/Ry fields are 2 bits)

- CLKb  in  1  clock; all flops update on the falling edge
- RSTb  in  1  asynchronous active-low reset
- INSTR  in  N  instruction word: [9:8] class, [7:6] rx, [5:4] ry, [3:0] FN (class 00) or [5:0] imm (class 10/11)
- IVALID  in  1  INSTR valid
- IREADY  out  1  controller can accept an instruction
- IR_BUS  out  N  latched instruction, driven onto the bus when EXTout=1
- EXTout  out  1  IR_BUS drives the shared bus
- Rout  out  NREG  one-hot register-to-bus enable
- Rin  out  NREG  one-hot bus-to-register load enable
- Ain  out  1  ALU A-operand capture
- Gin  out  1  ALU result capture
- Gout  out  1  ALU result drives the bus
- FN  out  4  ALU function code
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  illegal-instruction pulse (present only with the macro)

## Operation
- Classes: 00 = register ALU op (Rx ← Rx FN Ry); 01 = MOV (Rx ← Ry); 10 = ADDI (Rx ← Rx + imm); 11 = SUBI (Rx ← Rx − imm).
- States: IDLE, T1, T2, T3, FIN.
- IDLE: IREADY=1. When IVALID=1 at a falling edge, latch INSTR into IR and go to T1. Otherwise stay in IDLE.
- T1, class 01: Rout[ry]=1 and Rin[rx]=1, then go to FIN.
- T1, other classes: Rout[rx]=1 and Ain=1, then go to T2.
- T2, class 00: Rout[ry]=1 and Gin=1.
- T2, class 10/11: EXTout=1 and Gin=1.
- T2, all classes: go to T3.
- T3: Gout=1 and Rin[rx]=1, then go to FIN.
- FIN: DONE=1, then go to IDLE.
- FN = IR[3:0] from T1 through T3 for class 00. Otherwise FN = 0000.
- Outputs are decoded combinationally from the state register and IR. Only the listed signals are high in each state; all others are 0.
- Bus invariant: at most one of Rout bits, EXTout, and Gout is high in any cycle.
- rx == ry is legal; no special handling.
- IVALID while not in IDLE is ignored. IR holds its value until the next accepted instruction.

## Timing
- Latency from the accepting edge to DONE high: ALU/ADDI/SUBI take 4 cycles (T1, T2, T3, FIN); MOV takes 2 cycles (T1, FIN).
- Throughput: a new instruction is accepted in the cycle after FIN. There are no back-to-back accepts.
- Ain is high for exactly one cycle, and Gin is high for exactly one cycle (T2). The result is written to Rx at the falling edge that ends T3.
- Reset (asynchronous, any state including mid-instruction): state=IDLE, IR=0, and all outputs 0.
- While RSTb=0, IREADY=0 (gated with RSTb). IREADY rises combinationally once RSTb releases.
- An aborted instruction writes nothing and produces no DONE.

## Configuration
- MSC_ILLEGAL_TRAP_EN defined:
  - Class-00 FN outside 0010–1011 is illegal.
  - For an illegal instruction, T1 goes directly to FIN with all T1 enables forced to 0, and ERR=1 for that one cycle. No register is written.
  - DONE still pulses in FIN.
- MSC_ILLEGAL_TRAP_EN undefined:
  - There is no ERR port.
  - Every FN executes the normal sequence.

## Structure
- Package msc_pkg holds:
  - state enum (IDLE, T1, T2, T3, FIN)
  - class codes (CLS_ALU, CLS_MOV, CLS_ADDI, CLS_SUBI)
  - FN constants (ADD=0010, SUB=0011, INV=0100, FLP=0101, AND=0110, OR=0111, XOR=1000, LSL=1001, LSR=1010, ASR=1011)
  - field bit positions
- Sub-module msc_decoder (combinational): IR → class, one-hot rx, one-hot ry, legal flag.

## Test plan
- Reset, then IVALID with INSTR=00_01_10_0010 (ADD R1,R2): T1 Rout=0010,Ain; T2 Rout=0100,Gin,FN=0010; T3 Gout,Rin=0010; FIN DONE at cycle 4.
- INSTR=10_11_000101 (ADDI R3,#5): T2 EXTout=1, IR_BUS=1011000101, Rout=0000; T3 Rin=1000; DONE at cycle 4.
- INSTR=01_00_11_0000 (MOV R0,R3): T1 Rout=1000,Rin=0001; DONE at cycle 2; Ain, Gin, Gout stay 0.
- Hold IVALID=1 with two instructions queued: second accepted only in the cycle after FIN. IREADY=0 during T1–FIN, and the bus invariant holds every cycle.
- Assert RSTb=0 during T2 of SUB: all outputs go to 0 immediately. After release: IDLE, no DONE, Rin never asserted.
- With MSC_ILLEGAL_TRAP_EN, INSTR=00_01_10_1111: ERR and DONE pulse in the same cycle at cycle 2, Rin stays 0000.

Source files
------------

// File: rtl/msc_pkg.sv
// Shared types and constants for the multi-stage instruction sequencer.
package msc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        FIN  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_MOV  = 2'b01,
        CLS_ADDI = 2'b10,
        CLS_SUBI = 2'b11
    } cls_t;

    localparam logic [3:0] FN_ADD = 4'b0010;
    localparam logic [3:0] FN_SUB = 4'b0011;
    localparam logic [3:0] FN_INV = 4'b0100;
    localparam logic [3:0] FN_FLP = 4'b0101;
    localparam logic [3:0] FN_AND = 4'b0110;
    localparam logic [3:0] FN_OR  = 4'b0111;
    localparam logic [3:0] FN_XOR = 4'b1000;
    localparam logic [3:0] FN_LSL = 4'b1001;
    localparam logic [3:0] FN_LSR = 4'b1010;
    localparam logic [3:0] FN_ASR = 4'b1011;

    // Instruction field positions (fixed for a 10-bit instruction word)
    localparam int CLS_HI = 9;
    localparam int CLS_LO = 8;
    localparam int RX_HI  = 7;
    localparam int RX_LO  = 6;
    localparam int RY_HI  = 5;
    localparam int RY_LO  = 4;
    localparam int FN_HI  = 3;
    localparam int FN_LO  = 0;

endpackage

// File: rtl/msc_decoder.sv
// Combinational instruction decode: class, one-hot register selects and
// legality of the ALU function code.
module msc_decoder
    import msc_pkg::*;
#(
    parameter int N    = 10,
    parameter int NREG = 4
) (
    input  logic [N-1:0]    ir_i,
    output cls_t            cls_o,
    output logic [NREG-1:0] rx_oh_o,
    output logic [NREG-1:0] ry_oh_o,
    output logic            legal_o
);

    logic [1:0] rx;
    logic [1:0] ry;
    logic [3:0] fn;

    assign cls_o   = cls_t'(ir_i[CLS_HI:CLS_LO]);
    assign rx      = ir_i[RX_HI:RX_LO];
    assign ry      = ir_i[RY_HI:RY_LO];
    assign fn      = ir_i[FN_HI:FN_LO];

    assign rx_oh_o = NREG'(1) << rx;
    assign ry_oh_o = NREG'(1) << ry;

    // Only the ALU class carries a function code; the other classes are always legal
    assign legal_o = (cls_o != CLS_ALU) || ((fn >= FN_ADD) && (fn <= FN_ASR));

endmodule

// File: rtl/multi_stage_controller.sv
// Falling-edge instruction sequencer driving ALU and register-file controls.
// Optional macro MSC_ILLEGAL_TRAP_EN adds the ERR port and illegal-FN trapping.
module multi_stage_controller
    import msc_pkg::*;
#(
    parameter int N    = 10,
    parameter int NREG = 4
) (
    input  logic            CLKb,
    input  logic            RSTb,
    input  logic [N-1:0]    INSTR,
    input  logic            IVALID,
    output logic            IREADY,
    output logic [N-1:0]    IR_BUS,
    output logic            EXTout,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic [3:0]      FN,
    output logic            DONE
`ifdef MSC_ILLEGAL_TRAP_EN
    ,
    output logic            ERR
`endif
);

    state_t          state_q, state_d;
    logic [N-1:0]    ir_q, ir_d;
    cls_t            cls;
    logic [NREG-1:0] rx_oh;
    logic [NREG-1:0] ry_oh;
    logic            legal;
    logic            trap;
    logic [3:0]      fn_alu;

    msc_decoder #(.N(N), .NREG(NREG)) u_dec (
        .ir_i    (ir_q),
        .cls_o   (cls),
        .rx_oh_o (rx_oh),
        .ry_oh_o (ry_oh),
        .legal_o (legal)
    );

`ifdef MSC_ILLEGAL_TRAP_EN
    assign trap = ~legal;
`else
    logic unused_legal;
    assign unused_legal = legal;
    assign trap         = 1'b0;
`endif

    assign fn_alu = ((cls == CLS_ALU) && !trap) ? ir_q[FN_HI:FN_LO] : 4'b0000;

    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        IREADY  = 1'b0;
        EXTout  = 1'b0;
        Rout    = '0;
        Rin     = '0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        FN      = 4'b0000;
        DONE    = 1'b0;
`ifdef MSC_ILLEGAL_TRAP_EN
        ERR     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                // Gated so the upstream never sees ready while reset is held
                IREADY = RSTb;
                if (IVALID) begin
                    ir_d    = INSTR;
                    state_d = T1;
                end
            end
            T1: begin
                FN = fn_alu;
                if (cls == CLS_MOV) begin
                    Rout    = ry_oh;
                    Rin     = rx_oh;
                    state_d = FIN;
                end else if (trap) begin
                    state_d = FIN;
                end else begin
                    Rout    = rx_oh;
                    Ain     = 1'b1;
                    state_d = T2;
                end
            end
            T2: begin
                FN  = fn_alu;
                Gin = 1'b1;
                if (cls == CLS_ALU) begin
                    Rout = ry_oh;
                end else begin
                    EXTout = 1'b1;
                end
                state_d = T3;
            end
            T3: begin
                FN      = fn_alu;
                Gout    = 1'b1;
                Rin     = rx_oh;
                state_d = FIN;
            end
            FIN: begin
                DONE    = 1'b1;
`ifdef MSC_ILLEGAL_TRAP_EN
                ERR     = trap;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The latched instruction is only visible on the bus while it is the driver
    assign IR_BUS = EXTout ? ir_q : '0;

endmodule
